// File: rtl/mbp_choice_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mbp_choice_arbiter
// Purpose  : Tournament chooser for the multiple branch predictor. It holds
//            one saturating confidence counter per component predictor in
//            every chooser entry, and picks the most confident valid
//            component for each fetch slot. A 2-stage read-modify-write
//            pipeline trains the counters. A sweep FSM clears the table after
//            reset and on a flush.
// Ports    : clk_i / rst_ni          clock, asynchronous active-low reset
//            flush_bp_i              start a clear sweep
//            debug_mode_i            suppress training
//            vpc_i                   fetch PC (cycle N)
//            comp_valid_i/taken_i    per-slot component predictions (N+1)
//            upd_*                   resolved branch update
//            select_valid_o/taken_o  chosen prediction per slot
//            select_comp_o           chosen component index per slot
//            flush_busy_o            sweep in progress
// Revision : 1.0 - initial release
// ============================================================================
module mbp_choice_arbiter #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned NR_ENTRIES      = 64,
  parameter int unsigned NUM_COMP        = 3,
  parameter int unsigned CTR_BITS        = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_bp_i,
  input  logic                                        debug_mode_i,
  input  logic [VLEN-1:0]                             vpc_i,
  input  logic [NUM_COMP*INSTR_PER_FETCH-1:0]         comp_valid_i,
  input  logic [NUM_COMP*INSTR_PER_FETCH-1:0]         comp_taken_i,
  input  logic                                        upd_valid_i,
  input  logic [VLEN-1:0]                             upd_pc_i,
  input  logic                                        upd_taken_i,
  input  logic [NUM_COMP-1:0]                         upd_comp_valid_i,
  input  logic [NUM_COMP-1:0]                         upd_comp_taken_i,
  output logic [INSTR_PER_FETCH-1:0]                  select_valid_o,
  output logic [INSTR_PER_FETCH-1:0]                  select_taken_o,
  output logic [$clog2(NUM_COMP)*INSTR_PER_FETCH-1:0] select_comp_o,
  output logic                                        flush_busy_o
);

  localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned SLOT_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned ROW_W     = (ROW_BITS  > 0) ? ROW_BITS  : 1;
  localparam int unsigned SLOT_W    = (SLOT_BITS > 0) ? SLOT_BITS : 1;
  localparam int unsigned CSEL      = $clog2(NUM_COMP);

  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(NR_ROWS - 1);

  typedef logic [CTR_BITS-1:0] ctr_t;

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Index fields collapse to a constant 0 when their width would be zero.
  function automatic logic [ROW_W-1:0] pc_row(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] sh;
    sh = pc >> (1 + SLOT_BITS);
    return (ROW_BITS > 0) ? sh[ROW_W-1:0] : '0;
  endfunction

  function automatic logic [SLOT_W-1:0] pc_slot(input logic [VLEN-1:0] pc);
    logic [VLEN-1:0] sh;
    sh = pc >> 1;
    return (SLOT_BITS > 0) ? sh[SLOT_W-1:0] : '0;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q;
  logic [ROW_W-1:0]    sweep_row_q;
  logic [ROW_W-1:0]    fetch_row_q;

  logic                upd_vld_q;
  logic [ROW_W-1:0]    upd_row_q;
  logic [SLOT_W-1:0]   upd_slot_q;
  logic                upd_taken_q;
  logic [NUM_COMP-1:0] upd_cv_q;
  logic [NUM_COMP-1:0] upd_ct_q;

  ctr_t ctr_q [NR_ROWS][INSTR_PER_FETCH][NUM_COMP];

  // PC bits outside the index fields are intentionally ignored.
  logic w_unused;
  assign w_unused = ^{vpc_i, upd_pc_i};

  // --------------------------------------------------------------------------
  // Sweep FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_SWEEP;
      sweep_row_q <= '0;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          if (flush_bp_i) begin
            sweep_row_q <= '0;
          end else if (sweep_row_q == LAST_ROW) begin
            state_q     <= ST_IDLE;
            sweep_row_q <= '0;
          end else begin
            sweep_row_q <= sweep_row_q + ROW_W'(1);
          end
        end
        ST_IDLE: begin
          if (flush_bp_i) begin
            state_q     <= ST_SWEEP;
            sweep_row_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_SWEEP;
          sweep_row_q <= '0;
        end
      endcase
    end
  end

  assign flush_busy_o = (state_q == ST_SWEEP);

  // --------------------------------------------------------------------------
  // Training stage U: accept only updates that can change relative confidence
  // (at least one valid component right and at least one wrong).
  // --------------------------------------------------------------------------
  logic [NUM_COMP-1:0] w_upd_wrong;
  logic                w_upd_accept;
  logic                w_train_en;

  assign w_upd_wrong  = upd_comp_taken_i ^ {NUM_COMP{upd_taken_i}};
  assign w_upd_accept = upd_valid_i && !debug_mode_i && !flush_bp_i &&
                        (state_q == ST_IDLE) &&
                        (|(upd_comp_valid_i & ~w_upd_wrong)) &&
                        (|(upd_comp_valid_i &  w_upd_wrong));

  // A flush in the same cycle kills the pending write-back.
  assign w_train_en = upd_vld_q && !flush_bp_i && (state_q == ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_row_q <= '0;
      upd_vld_q   <= 1'b0;
      upd_row_q   <= '0;
      upd_slot_q  <= '0;
      upd_taken_q <= 1'b0;
      upd_cv_q    <= '0;
      upd_ct_q    <= '0;
    end else begin
      fetch_row_q <= pc_row(vpc_i);
      upd_vld_q   <= w_upd_accept;
      if (w_upd_accept) begin
        upd_row_q   <= pc_row(upd_pc_i);
        upd_slot_q  <= pc_slot(upd_pc_i);
        upd_taken_q <= upd_taken_i;
        upd_cv_q    <= upd_comp_valid_i;
        upd_ct_q    <= upd_comp_taken_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Training stage U+1: the array is read directly, so a write committed on
  // the previous edge is already visible to a back-to-back update.
  // --------------------------------------------------------------------------
  ctr_t w_new [NUM_COMP];

  always_comb begin
    for (int c = 0; c < NUM_COMP; c++) begin
      w_new[c] = ctr_q[upd_row_q][upd_slot_q][c];
      if (upd_cv_q[c]) begin
        if (upd_ct_q[c] == upd_taken_q) begin
          if (w_new[c] != CTR_MAX) w_new[c] = w_new[c] + ctr_t'(1);
        end else begin
          if (w_new[c] != '0) w_new[c] = w_new[c] - ctr_t'(1);
        end
      end
    end
  end

  // One row-wide write port shared by the sweep and the trainer.
  logic             w_wr_en;
  logic [ROW_W-1:0] w_wr_row;
  ctr_t             w_wr_data [INSTR_PER_FETCH][NUM_COMP];

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_row = upd_row_q;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      for (int c = 0; c < NUM_COMP; c++) begin
        w_wr_data[s][c] = ctr_q[upd_row_q][s][c];
      end
    end
    if (state_q == ST_SWEEP) begin
      w_wr_en  = 1'b1;
      w_wr_row = sweep_row_q;
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        for (int c = 0; c < NUM_COMP; c++) begin
          w_wr_data[s][c] = CTR_INIT;
        end
      end
    end else if (w_train_en) begin
      w_wr_en = 1'b1;
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        if (SLOT_W'(s) == upd_slot_q) begin
          for (int c = 0; c < NUM_COMP; c++) begin
            w_wr_data[s][c] = w_new[c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        for (int c = 0; c < NUM_COMP; c++) begin
          ctr_q[w_wr_row][s][c] <= w_wr_data[s][c];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read with write-first bypass, then per-slot selection.
  // --------------------------------------------------------------------------
  ctr_t w_rd [INSTR_PER_FETCH][NUM_COMP];

  always_comb begin
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      for (int c = 0; c < NUM_COMP; c++) begin
        w_rd[s][c] = (w_wr_en && (w_wr_row == fetch_row_q)) ?
                     w_wr_data[s][c] : ctr_q[fetch_row_q][s][c];
      end
    end
  end

  for (genvar s = 0; s < INSTR_PER_FETCH; s++) begin : g_slot
    logic            w_found;
    ctr_t            w_best;
    logic [CSEL-1:0] w_idx;
    logic            w_tk;

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
      w_found = 1'b0;
      w_best  = '0;
      w_idx   = '0;
      w_tk    = 1'b0;
      for (int c = 0; c < NUM_COMP; c++) begin
        if (comp_valid_i[s*NUM_COMP + c] && (!w_found || (w_rd[s][c] > w_best))) begin
          w_found = 1'b1;
          w_best  = w_rd[s][c];
          w_idx   = CSEL'(c);
          w_tk    = comp_taken_i[s*NUM_COMP + c];
        end
      end
    end

    logic w_sel;
    assign w_sel = w_found && (state_q == ST_IDLE);

    assign select_valid_o[s]               = w_sel;
    assign select_taken_o[s]               = w_sel ? w_tk  : 1'b0;
    assign select_comp_o[s*CSEL +: CSEL]   = w_sel ? w_idx : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mbp_choice_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbp_choice_arbiter
// Purpose  : Directed, table-driven self-checking bench for the chooser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbp_choice_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_bp_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [63:0] vpc_i = '0;
  logic [5:0]  comp_valid_i = '0;
  logic [5:0]  comp_taken_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [63:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [2:0]  upd_comp_valid_i = '0;
  logic [2:0]  upd_comp_taken_i = '0;
  logic [1:0]  select_valid_o;
  logic [1:0]  select_taken_o;
  logic [3:0]  select_comp_o;
  logic        flush_busy_o;

  always #5 clk_i = ~clk_i;

  mbp_choice_arbiter #(
    .VLEN(64), .INSTR_PER_FETCH(2), .NR_ENTRIES(64), .NUM_COMP(3), .CTR_BITS(2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_bp_i       (flush_bp_i),
    .debug_mode_i     (debug_mode_i),
    .vpc_i            (vpc_i),
    .comp_valid_i     (comp_valid_i),
    .comp_taken_i     (comp_taken_i),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_comp_valid_i (upd_comp_valid_i),
    .upd_comp_taken_i (upd_comp_taken_i),
    .select_valid_o   (select_valid_o),
    .select_taken_o   (select_taken_o),
    .select_comp_o    (select_comp_o),
    .flush_busy_o     (flush_busy_o)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // comp bit index = slot*3 + component; select_comp_o = {slot1, slot0}
  typedef struct packed {
    logic [63:0] pc;
    logic [5:0]  cv;
    logic [5:0]  ct;
    logic [1:0]  ev;
    logic [1:0]  et;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl [12];

  task automatic chk_out(input string nm, input logic [1:0] ev, input logic [1:0] et,
                         input logic [3:0] ec);
    n_vec++;
    if (select_valid_o !== ev || select_taken_o !== et || select_comp_o !== ec) begin
      n_miss++;
      $display("FAIL %s: got valid=%b taken=%b comp=%b, expected valid=%b taken=%b comp=%b",
               nm, select_valid_o, select_taken_o, select_comp_o, ev, et, ec);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Call at a negedge: row registers on the next posedge, checked one cycle on.
  task automatic fetch(input string nm, input logic [63:0] pc, input logic [5:0] cv,
                       input logic [5:0] ct, input logic [1:0] ev, input logic [1:0] et,
                       input logic [3:0] ec);
    vpc_i        = pc;
    comp_valid_i = '0;
    comp_taken_i = '0;
    @(negedge clk_i);
    comp_valid_i = cv;
    comp_taken_i = ct;
    #1 chk_out(nm, ev, et, ec);
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk, input logic [2:0] cv,
                     input logic [2:0] ct);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_taken_i      = tk;
    upd_comp_valid_i = cv;
    upd_comp_taken_i = ct;
    @(negedge clk_i);
  endtask

  task automatic upd_idle(input int n);
    upd_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  // Called at a negedge while busy; counts cycles until busy drops.
  task automatic count_busy(input string nm);
    int   cnt;
    logic leak;
    cnt  = 0;
    leak = 1'b0;
    comp_valid_i = '1;
    comp_taken_i = '1;
    while (flush_busy_o === 1'b1 && cnt < 200) begin
      #1;
      if (select_valid_o !== 2'b00) leak = 1'b1;
      cnt++;
      @(negedge clk_i);
    end
    chk_int({nm, " busy cycles"}, cnt, 32);
    chk_int({nm, " valid during sweep"}, int'(leak), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            pc        cv         ct         ev     et     ec
    tbl[0]  = '{64'h40, 6'b111111, 6'b001010, 2'b11, 2'b11, 4'b0001};
    tbl[1]  = '{64'h40, 6'b110001, 6'b100000, 2'b11, 2'b10, 4'b1000};
    tbl[2]  = '{64'h44, 6'b000101, 6'b000100, 2'b01, 2'b01, 4'b0010};
    tbl[3]  = '{64'h44, 6'b111011, 6'b001000, 2'b11, 2'b10, 4'b0001};
    tbl[4]  = '{64'h8C, 6'b000101, 6'b000001, 2'b01, 2'b01, 4'b0000};
    tbl[5]  = '{64'h90, 6'b000101, 6'b000000, 2'b01, 2'b00, 4'b0000};
    tbl[6]  = '{64'h00, 6'b111111, 6'b111111, 2'b11, 2'b11, 4'b0000};
    tbl[7]  = '{64'h40, 6'b100000, 6'b100000, 2'b10, 2'b10, 4'b1000};
    tbl[8]  = '{64'h40, 6'b000000, 6'b111111, 2'b00, 2'b00, 4'b0000};
    tbl[9]  = '{64'h42, 6'b111111, 6'b001010, 2'b11, 2'b11, 4'b0001};
    tbl[10] = '{64'hC0, 6'b110001, 6'b100000, 2'b11, 2'b10, 4'b1000};
    tbl[11] = '{64'h7E, 6'b111111, 6'b000000, 2'b11, 2'b00, 4'b0000};

    // Reset values
    comp_valid_i = '1;
    comp_taken_i = '1;
    repeat (3) @(negedge clk_i);
    #1 chk_out("reset outputs", 2'b00, 2'b00, 4'h0);
    chk_int("reset busy", int'(flush_busy_o), 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    count_busy("reset sweep");
    fetch("post-reset tie", 64'h0, 6'b111111, 6'b111111, 2'b11, 2'b11, 4'h0);

    // Row 16 slot 0: c0 wrong, c1/c2 right, three times -> (0,3,3)
    @(negedge clk_i);
    repeat (3) upd(64'h40, 1'b1, 3'b111, 3'b110);
    upd_idle(2);
    // Row 16 slot 1: c0 right, c1 wrong -> (3,1,2)
    upd(64'h42, 1'b0, 3'b011, 3'b010);
    upd_idle(2);

    // Row 17: back-to-back updates, fetch the row while they write
    vpc_i        = 64'h44;
    comp_valid_i = '0;
    upd(64'h44, 1'b1, 3'b011, 3'b010);          // -> (1,3,2)
    comp_valid_i = 6'b000101;
    comp_taken_i = 6'b000000;
    #1 chk_out("bypass first write", 2'b01, 2'b00, 4'b0010);
    upd(64'h44, 1'b1, 3'b111, 3'b010);          // -> (0,3,1)
    #1 chk_out("bypass second write", 2'b01, 2'b00, 4'b0010);
    upd_idle(2);

    // Non-training updates: all valid components agree, then debug mode
    repeat (5) upd(64'h8C, 1'b1, 3'b011, 3'b000);
    upd_idle(1);
    debug_mode_i = 1'b1;
    repeat (5) upd(64'h90, 1'b1, 3'b011, 3'b010);
    upd_idle(2);
    debug_mode_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      fetch($sformatf("vec%0d", i), tbl[i].pc, tbl[i].cv, tbl[i].ct,
            tbl[i].ev, tbl[i].et, tbl[i].ec);
    end

    // Flush while an update sits in its write-back stage
    @(negedge clk_i);
    upd(64'h40, 1'b1, 3'b111, 3'b001);
    upd_valid_i = 1'b0;
    flush_bp_i  = 1'b1;
    @(negedge clk_i);
    flush_bp_i  = 1'b0;
    count_busy("flush sweep");
    fetch("after flush row16", 64'h40, 6'b111111, 6'b111111, 2'b11, 2'b11, 4'b0000);
    fetch("after flush row17", 64'h44, 6'b000101, 6'b000100, 2'b01, 2'b00, 4'b0000);

    // Flush during a sweep restarts it from row 0
    @(negedge clk_i);
    flush_bp_i = 1'b1;
    @(negedge clk_i);
    flush_bp_i = 1'b0;
    repeat (10) @(negedge clk_i);
    flush_bp_i = 1'b1;
    @(negedge clk_i);
    flush_bp_i = 1'b0;
    count_busy("restart sweep");
    fetch("after restart", 64'h7E, 6'b111111, 6'b000000, 2'b11, 2'b00, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mbp_choice_arbiter.md
Name: mbp_choice_arbiter

Overview:
Generalised tournament chooser for the multiple branch predictor (mbp). It selects, per fetch slot, among NUM_COMP component predictors (e.g. global, local, loop) using a per-entry, per-component saturating confidence counter held in a flop array. On resolve, it trains with a 2-stage read-modify-write pipeline. A sweep FSM handles reset and flush. It sits beside the component predictor RAMs in the frontend and replaces the fixed 2-way choice table.

Parameters:
VLEN, 64, virtual PC width
INSTR_PER_FETCH, 2, fetch slots per row (power of 2, ≥1)
NR_ENTRIES, 64, total chooser entries (power of 2, ≥ INSTR_PER_FETCH)
NUM_COMP, 3, number of component predictors (2..8)
CTR_BITS, 2, confidence counter width (1..4)
Derived: NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH; ROW_BITS = clog2(NR_ROWS); SLOT_BITS = clog2(INSTR_PER_FETCH); CSEL = clog2(NUM_COMP); INIT = 2^(CTR_BITS-1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_bp_i  in  1  start clear sweep
debug_mode_i  in  1  suppress training
vpc_i  in  VLEN  fetch PC, cycle N
comp_valid_i  in  NUM_COMP*INSTR_PER_FETCH  component prediction valid per slot, cycle N+1
comp_taken_i  in  NUM_COMP*INSTR_PER_FETCH  component taken per slot, cycle N+1
upd_valid_i  in  1  resolved branch update
upd_pc_i  in  VLEN  branch PC
upd_taken_i  in  1  actual outcome
upd_comp_valid_i  in  NUM_COMP  component had a prediction at fetch
upd_comp_taken_i  in  NUM_COMP  component prediction at fetch
select_valid_o  out  INSTR_PER_FETCH  chosen prediction valid
select_taken_o  out  INSTR_PER_FETCH  chosen direction
select_comp_o  out  CSEL*INSTR_PER_FETCH  chosen component index
flush_busy_o  out  1  sweep in progress

Behaviour:
- Indexing: row = pc[1+SLOT_BITS +: ROW_BITS]; slot = pc[1 +: SLOT_BITS]. Index fields are zero width when SLOT_BITS or ROW_BITS is 0.
- Read, 1-cycle latency: row from vpc_i is registered at cycle N. In cycle N+1 the row's counters are read combinationally and combined with comp_*_i to produce the outputs.
- Selection per slot: among components with comp_valid=1, choose the highest counter; ties go to the lowest index. If no component is valid, select_valid_o=0, select_taken_o=0, select_comp_o=0.
- Training stage U: capture the update. Stage U+1: read the entry, compute, write back.
- Training only happens if at least one upd_comp_valid component agrees with upd_taken and at least one disagrees.
- For each valid component: correct → +1 saturating at 2^CTR_BITS-1; wrong → −1 saturating at 0. Invalid components are unchanged.
- Back-to-back updates to the same entry: the stage U+1 computation uses the value just written (forwarded). No lost increments.
- Read/write collision: if the registered fetch row equals the row being written in the same cycle, outputs use the post-write counters (write-first bypass).
- Updates are dropped while debug_mode_i=1, while flush_busy_o=1, or when upd_valid_i=0. An update already in stage U+1 when flush starts is discarded.
- FSM states:
  - SWEEP: row counter r writes INIT to all counters of row r, one row per cycle. Exits to IDLE after row NR_ROWS-1.
  - IDLE: normal operation.
- Asynchronous reset forces SWEEP with r=0 and clears all pipeline registers.
- In IDLE, flush_bp_i=1 enters SWEEP with r=0 next cycle. flush_bp_i asserted during SWEEP restarts r=0.
- flush_busy_o=1 in SWEEP. While in SWEEP, select_valid_o=0.
- Reset values: select_valid_o=0, select_taken_o=0, select_comp_o=0, flush_busy_o=1.
- After reset release, sweep takes exactly NR_ROWS cycles; flush_busy_o falls on the cycle after row NR_ROWS-1 is written.

Test Plan:
1. Reset, then count cycles → flush_busy_o high for exactly 32 cycles, then low. Any fetch afterwards with all three components valid → select_comp_o=0 (all counters 2, tie).
2. Entry at pc 0x40, slot 0: 3 updates with upd_taken=1, comp taken {c0=0, c1=1, c2=1} → c0=0, c1=3, c2=3. Next fetch of 0x40 with comp_taken c1=1, c2=0 → select_comp_o=1, select_taken_o=1.
3. Two updates to pc 0x44 on consecutive cycles with c0 wrong, c1 right → counters c0=0, c1=3 (forwarding verified). Fetch of the same row during the second write cycle → bypassed values seen.
4. All components agree, or debug_mode_i=1, then 10 updates → counters unchanged, all at 2.
5. flush_bp_i during update stage U+1 → that write is discarded. After 32 cycles all entries read INIT and select_comp_o=0.
6. comp_valid_i only for c2 in slot 1 → select_comp_o[slot1]=2. comp_valid_i=0 for all components → select_valid_o[slot1]=0.
